// File: rtl/shift_add_mul_if.sv
// Handshake/data bundle for shift_add_mul.
//   master: drives start, data_a, data_b (and sgn when SIGNED_MUL_EN is defined)
//   slave : drives product, busy, done
// Macro SIGNED_MUL_EN adds the sgn signal to the bundle.
interface shift_add_mul_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     data_a;
    logic [WIDTH-1:0]     data_b;
`ifdef SIGNED_MUL_EN
    logic                 sgn;
`endif
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

`ifdef SIGNED_MUL_EN
    modport master (output start, data_a, data_b, sgn, input product, busy, done);
    modport slave  (input start, data_a, data_b, sgn, output product, busy, done);
`else
    modport master (output start, data_a, data_b, input product, busy, done);
    modport slave  (input start, data_a, data_b, output product, busy, done);
`endif
endinterface

// File: rtl/shift_add_mul.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - shift_add_mul_if.slave: start/data_a/data_b[/sgn] in,
//            product (registered, 2*WIDTH), busy, done (1-cycle pulse) out
// Optional feature: define SIGNED_MUL_EN to add the sgn input; sgn=1 at accept
// multiplies two's-complement operands (magnitudes, result negated on sign mismatch).
module shift_add_mul #(
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_add_mul_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [PW-1:0]    mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [PW-1:0]    acc_q,     acc_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [PW-1:0]    product_q, product_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    sum;

`ifdef SIGNED_MUL_EN
    logic             neg_q,     neg_d;
    logic             neg_in;

    // Magnitudes of the incoming operands; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        mag_a  = (bus.sgn && bus.data_a[WIDTH-1]) ? WIDTH'(~bus.data_a + WIDTH'(1)) : bus.data_a;
        mag_b  = (bus.sgn && bus.data_b[WIDTH-1]) ? WIDTH'(~bus.data_b + WIDTH'(1)) : bus.data_b;
        neg_in = bus.sgn && (bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1]);
    end
`else
    always_comb begin
        mag_a = bus.data_a;
        mag_b = bus.data_b;
    end
`endif

    // Accumulator value after the current RUN iteration.
    always_comb begin
        sum = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef SIGNED_MUL_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = PW'(mag_a);
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
`ifdef SIGNED_MUL_EN
                    neg_d    = neg_in;
`endif
                    // Zero operand skips the iterations entirely.
                    if (bus.data_a == '0 || bus.data_b == '0) begin
                        state_d   = S_DONE;
                        product_d = '0;
                    end else begin
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                // Last iteration: result goes straight into product on DONE entry.
                if (cnt_q == CW'(1)) begin
                    state_d   = S_DONE;
`ifdef SIGNED_MUL_EN
                    product_d = neg_q ? PW'(-sum) : sum;
`else
                    product_d = sum;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SIGNED_MUL_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SIGNED_MUL_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
